// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Front-end conditioning for the board's raw slide switches and push-buttons.
// Feeds the memory-mapped input read path (io_sw_i / io_btn_i).
//
//   - Two-flop synchroniser on all 36 asynchronous pad inputs.
//   - Per-button stability counter: a button's debounced level only changes
//     after DB_CNT_MAX consecutive cycles of disagreement with the stable level.
//   - Registered one-cycle rise pulse per debounced press (release: no pulse).
//   - Optional sticky press latch, enabled by defining the macro
//     INPUT_DEBOUNCER_LATCH_EN. When enabled, o_btn reports the sticky flag,
//     which is cleared by i_btn_ack; when disabled, o_btn is the debounced
//     level and i_btn_ack is ignored.
//
// Parameters:
//   DB_CNT_MAX     consecutive mismatch cycles before the level flips (>= 1)
//   CNT_W          debounce counter width
//   BTN_ACTIVE_LOW 1: raw button pads read 0 when pressed
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous, active-high reset
//   i_sw[31:0]  raw slide-switch pads (asynchronous)
//   i_btn[3:0]  raw push-button pads (asynchronous)
//   i_btn_ack   per-button clear of the sticky flag (latch build only)
//   o_sw        synchronised switches
//   o_btn       button status, 1 = pressed (or sticky flag in latch build)
//   o_btn_rise  one-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int DB_CNT_MAX     = 500000,
  parameter int CNT_W          = $clog2(DB_CNT_MAX + 1),
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_sw,
  input  logic [3:0]  i_btn,
  input  logic [3:0]  i_btn_ack,
  output logic [31:0] o_sw,
  output logic [3:0]  o_btn,
  output logic [3:0]  o_btn_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);

  // -------------------------------------------------------------------------
  // Synchroniser. Buttons are normalised to pressed = 1 before the first
  // stage, so reset leaves every stage at the "released" value.
  // -------------------------------------------------------------------------
  logic [3:0]  btn_n;
  logic [31:0] sw_s1, sw_s2;
  logic [3:0]  btn_s1, btn_s2;

  assign btn_n = BTN_ACTIVE_LOW ? ~i_btn : i_btn;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      sw_s1  <= i_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
    end
  end

  assign o_sw = sw_s2;

  // -------------------------------------------------------------------------
  // Debounce and edge detect. Any agreement with the stable level restarts
  // the count, so only an unbroken run of DB_CNT_MAX mismatching cycles
  // flips db. The rise pulse is registered on the same edge that sets db,
  // so it occupies exactly the first cycle db reads 1.
  // -------------------------------------------------------------------------
  logic [3:0]       db;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      db   <= '0;
      rise <= '0;
      for (int b = 0; b < 4; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        rise[b] <= 1'b0;
        if (btn_s2[b] == db[b]) begin
          cnt[b] <= '0;
        end else if (cnt[b] == CNT_LAST) begin
          db[b]   <= btn_s2[b];
          cnt[b]  <= '0;
          rise[b] <= btn_s2[b];
        end else begin
          cnt[b] <= cnt[b] + 1'b1;
        end
      end
    end
  end

  assign o_btn_rise = rise;

  // -------------------------------------------------------------------------
  // Status output.
  // -------------------------------------------------------------------------
`ifdef INPUT_DEBOUNCER_LATCH_EN
  // Sticky flag: set by the rise pulse, cleared by ack; set wins when both
  // happen in the same cycle so a fresh press is never lost.
  logic [3:0] stk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stk <= '0;
    end else begin
      stk <= (stk & ~i_btn_ack) | rise;
    end
  end

  assign o_btn = stk;
`else
  // Ack has no function without the latch; the port is kept so the top
  // level is identical in both builds.
  logic unused_btn_ack;
  assign unused_btn_ack = ^i_btn_ack;

  assign o_btn = db;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer with DB_CNT_MAX = 4, active-low buttons.
// Inputs are driven 1 time unit after a rising edge and outputs are sampled
// at that same point, so a value checked after "tick n" is the state after
// the n-th edge following the drive. Expected values are hand-derived:
// switches appear 2 edges after the drive, buttons 2 + DB_CNT_MAX = 6 edges.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

  localparam int DB_CNT_MAX = 4;

  logic        clk;
  logic        i_rst;
  logic [31:0] i_sw;
  logic [3:0]  i_btn;
  logic [3:0]  i_btn_ack;
  logic [31:0] o_sw;
  logic [3:0]  o_btn;
  logic [3:0]  o_btn_rise;

  int tests;
  int fails;
  logic [31:0] exp_q[$];

  input_debouncer #(
    .DB_CNT_MAX     (DB_CNT_MAX),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_sw       (i_sw),
    .i_btn      (i_btn),
    .i_btn_ack  (i_btn_ack),
    .o_sw       (o_sw),
    .o_btn      (o_btn),
    .o_btn_rise (o_btn_rise)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, tests=%0d", tests);
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Debounced-level check; in the latch build o_btn reports the sticky flag
  // instead, which the latch section checks on its own.
  task automatic check_lvl(input string tag, input logic [3:0] exp);
`ifndef INPUT_DEBOUNCER_LATCH_EN
    check(tag, {28'd0, o_btn}, {28'd0, exp});
`else
    if (exp === 4'bxxxx) check(tag, {28'd0, o_btn}, 32'd0);
`endif
  endtask

  // Advance n cycles expecting no rise pulse and a steady level.
  task automatic quiet(input string tag, input int n, input logic [3:0] lvl);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_rise"}, {28'd0, o_btn_rise}, 32'd0);
      check_lvl({tag, "_lvl"}, lvl);
    end
  endtask

  logic [7:0] bpat;

  initial begin
    tests     = 0;
    fails     = 0;
    i_rst     = 1'b1;
    i_sw      = 32'hFFFF_FFFF;
    i_btn     = 4'b0000;
    i_btn_ack = 4'b0000;
    bpat      = 8'b1000_1000;

    // Reset held 3 cycles with all buttons pressed and all switches on.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_sw", o_sw, 32'd0);
      check("rst_btn", {28'd0, o_btn}, 32'd0);
      check("rst_rise", {28'd0, o_btn_rise}, 32'd0);
    end
    i_rst = 1'b0;
    tick();
    check("rel_sw_edge1", o_sw, 32'd0);
    exp_q.push_back(32'hFFFF_FFFF);
    tick();
    check("rel_sw_edge2", o_sw, exp_q.pop_front());
    quiet("rel_wait", 3, 4'h0);
    tick();
    check("rel_rise", {28'd0, o_btn_rise}, 32'hF);
    check_lvl("rel_btn", 4'hF);
    tick();
    check("rel_rise_once", {28'd0, o_btn_rise}, 32'h0);
    check_lvl("rel_btn_hold", 4'hF);

    // Release everything: level drops after 6 edges, no pulse.
    i_btn = 4'hF;
    quiet("relall", 5, 4'hF);
    tick();
    check_lvl("relall_lvl", 4'h0);
    check("relall_rise", {28'd0, o_btn_rise}, 32'h0);

    // Switch path: old value held through the first edge.
    i_sw = 32'hA5A5_0F0F;
    tick();
    check("sw_hold", o_sw, 32'hFFFF_FFFF);
    exp_q.push_back(32'hA5A5_0F0F);
    tick();
    check("sw_new", o_sw, exp_q.pop_front());

    // Clean press / release of button 2.
    i_btn = 4'b1011;
    quiet("press2", 5, 4'h0);
    tick();
    check("press2_rise", {28'd0, o_btn_rise}, 32'h4);
    check_lvl("press2_lvl", 4'b0100);
    tick();
    check("press2_once", {28'd0, o_btn_rise}, 32'h0);
    check_lvl("press2_hold", 4'b0100);
    i_btn = 4'hF;
    quiet("release2", 5, 4'b0100);
    tick();
    check_lvl("release2_lvl", 4'h0);
    check("release2_rise", {28'd0, o_btn_rise}, 32'h0);

    // Bounce on button 0: low 3, high 1, low 3, high -> rejected.
    for (int j = 0; j < 8; j++) begin
      i_btn = {3'b111, bpat[j]};
      tick();
      check("bounce_rise", {28'd0, o_btn_rise}, 32'h0);
      check_lvl("bounce_lvl", 4'h0);
    end
    quiet("bounce_settle", 6, 4'h0);
    i_btn = 4'b1110;
    quiet("hold0", 5, 4'h0);
    tick();
    check("hold0_rise", {28'd0, o_btn_rise}, 32'h1);
    check_lvl("hold0_lvl", 4'b0001);
    i_btn = 4'hF;
    quiet("rel0", 5, 4'b0001);
    tick();
    check_lvl("rel0_lvl", 4'h0);

    // Simultaneous press of buttons 3 and 0 while button 1 bounces in runs
    // of 2 pressed / 1 released.
    for (int j = 0; j < 9; j++) begin
      i_btn = {1'b0, 1'b1, (j % 3 == 2), 1'b0};
      tick();
      if (j + 1 < 6) begin
        check("simul_pre_rise", {28'd0, o_btn_rise}, 32'h0);
        check_lvl("simul_pre_lvl", 4'h0);
      end else if (j + 1 == 6) begin
        check("simul_rise", {28'd0, o_btn_rise}, 32'h9);
        check_lvl("simul_lvl", 4'b1001);
      end else begin
        check("simul_post_rise", {28'd0, o_btn_rise}, 32'h0);
        check_lvl("simul_post_lvl", 4'b1001);
      end
    end
    i_btn = 4'hF;
    quiet("simul_rel", 5, 4'b1001);
    tick();
    check_lvl("simul_rel_lvl", 4'h0);

    // Reset mid-count with button 2 held: count abandoned, re-qualified.
    i_btn = 4'b1011;
    tick();
    tick();
    tick();
    i_rst = 1'b1;
    tick();
    check("midrst_btn", {28'd0, o_btn}, 32'h0);
    check("midrst_rise", {28'd0, o_btn_rise}, 32'h0);
    check("midrst_sw", o_sw, 32'h0);
    i_rst = 1'b0;
    tick();
    check("midrst_sw1", o_sw, 32'h0);
    check("midrst_rise1", {28'd0, o_btn_rise}, 32'h0);
    exp_q.push_back(32'hA5A5_0F0F);
    tick();
    check("midrst_sw2", o_sw, exp_q.pop_front());
    quiet("midrst_wait", 3, 4'h0);
    tick();
    check("midrst_req_rise", {28'd0, o_btn_rise}, 32'h4);
    check_lvl("midrst_req_lvl", 4'b0100);

`ifndef INPUT_DEBOUNCER_LATCH_EN
    // Without the latch, ack has no effect on the level.
    i_btn_ack = 4'hF;
    tick();
    check("ack_ignored", {28'd0, o_btn}, 32'h4);
    i_btn_ack = 4'h0;
    i_btn = 4'hF;
    tick();
    check("ack_ignored2", {28'd0, o_btn}, 32'h4);
`else
    // Sticky latch on button 1.
    i_btn = 4'hF;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("latch_rst", {28'd0, o_btn}, 32'h0);
    i_btn = 4'b1101;
    for (int i = 0; i < 6; i++) tick();
    check("latch_rise", {28'd0, o_btn_rise}, 32'h2);
    check("latch_pre", {28'd0, o_btn}, 32'h0);
    tick();
    check("latch_set", {28'd0, o_btn}, 32'h2);
    i_btn = 4'hF;
    for (int i = 0; i < 8; i++) tick();
    check("latch_sticky", {28'd0, o_btn}, 32'h2);
    i_btn_ack = 4'b0010;
    tick();
    i_btn_ack = 4'b0000;
    check("latch_ack", {28'd0, o_btn}, 32'h0);
    tick();
    check("latch_ack_hold", {28'd0, o_btn}, 32'h0);
    i_btn = 4'b1101;
    for (int i = 0; i < 6; i++) tick();
    check("latch_rise2", {28'd0, o_btn_rise}, 32'h2);
    i_btn_ack = 4'b0010;
    tick();
    i_btn_ack = 4'b0000;
    check("latch_set_wins", {28'd0, o_btn}, 32'h2);
    tick();
    check("latch_set_wins2", {28'd0, o_btn}, 32'h2);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
